bsg_credit_token_pacer: RTL and testbench

//  Sits in the credit-returning (consumer) domain, directly upstream of the async credit counter.

---
 rtl/bsg_credit_token_pkg.sv | 26 ++
 rtl/bsg_credit_token_gap_timer.sv | 29 ++
 rtl/bsg_credit_token_pacer.sv | 156 +++++++++++++++
 tb/tb_bsg_credit_token_pacer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/bsg_credit_token_pkg.sv
// Shared types and width helpers for the credit-to-token pacer.
package bsg_credit_token_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_e;

  // Width of a counter that must hold 0..max_pending inclusive.
  function automatic int pending_width_f(input int max_pending);
    return $clog2(max_pending + 1);
  endfunction

  function automatic int gap_width_f(input int gap);
    return (gap == 0) ? 1 : $clog2(gap + 1);
  endfunction

  function automatic int partial_width_f(input int lg_decimation);
    return (lg_decimation == 0) ? 1 : lg_decimation;
  endfunction

  localparam int default_pw_lp  = pending_width_f(4);
  localparam int default_gw_lp  = gap_width_f(1);

endpackage

// File: rtl/bsg_credit_token_gap_timer.sv
// Loadable down-counter that flags the last cycle of the inter-token gap.
module bsg_credit_token_gap_timer #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               load_i,
  input  logic [width_p-1:0] load_val_i,
  output logic               done_o
);

  logic [width_p-1:0] count_r;

  // Count down once loaded; parks at zero between gaps.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_r <= '0;
    end else if (load_i) begin
      count_r <= load_val_i;
    end else if (count_r != '0) begin
      count_r <= count_r - width_p'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign done_o = (count_r == width_p'(1));

endmodule

// File: rtl/bsg_credit_token_pacer.sv
// Credit accumulator and rate-limited token pulse generator.
// Optional macro BSG_CREDIT_TOKEN_PACER_STATS_EN builds the 32-bit emitted-token counter.
module bsg_credit_token_pacer
  import bsg_credit_token_pkg::*;
#(
  parameter int lg_credit_to_token_decimation_p = 0,
  parameter int max_pending_tokens_p            = 4,
  parameter int token_gap_p                     = 1,
  localparam int pw_lp = pending_width_f(max_pending_tokens_p),
  localparam int cw_lp = partial_width_f(lg_credit_to_token_decimation_p)
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             credit_v_i,
  input  logic             token_en_i,
  output logic             token_o,
  output logic [pw_lp-1:0] pending_tokens_o,
  output logic [cw_lp-1:0] partial_credits_o,
  output logic             overflow_o,
  output logic [31:0]      total_tokens_o
);

  localparam int              d_lp   = lg_credit_to_token_decimation_p;
  localparam int              gw_lp  = gap_width_f(token_gap_p);
  localparam logic [pw_lp-1:0] max_lp = pw_lp'(max_pending_tokens_p);

  logic             tok_inc, tok_dec, gap_load, gap_done;
  logic [pw_lp-1:0] pending_r;
  logic             overflow_r, token_r;
  state_e           state_r, state_n;

  generate
    if (d_lp == 0) begin : g_no_acc
      assign tok_inc           = credit_v_i;
      assign partial_credits_o = 1'b0;
    end else begin : g_acc
      logic [d_lp-1:0] acc_r;
      // Wrapping credit accumulator; the all-ones wrap is what mints a token.
      always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
          acc_r <= '0;
        end else if (credit_v_i) begin
          acc_r <= acc_r + d_lp'(1);
        end else begin
          acc_r <= acc_r;
        end
      end
      assign tok_inc           = credit_v_i && (acc_r == '1);
      assign partial_credits_o = acc_r;
    end
  endgenerate

  // Pending tokens saturate at the configured depth; a dropped token is remembered.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pending_r  <= '0;
      overflow_r <= 1'b0;
    end else if (tok_inc && !tok_dec) begin
      if (pending_r == max_lp) begin
        overflow_r <= 1'b1;
      end else begin
        pending_r <= pending_r + pw_lp'(1);
      end
    end else if (tok_dec && !tok_inc) begin
      pending_r <= pending_r - pw_lp'(1);
    end else begin
      pending_r <= pending_r;
    end
  end

  generate
    if (token_gap_p > 0) begin : g_gap
      bsg_credit_token_gap_timer #(.width_p(gw_lp)) u_gap_timer (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .load_i     (gap_load),
        .load_val_i (gw_lp'(token_gap_p)),
        .done_o     (gap_done)
      );
    end else begin : g_no_gap
      assign gap_done = 1'b1;
    end
  endgenerate

  // Next state; tok_dec fires on every edge that launches a pulse.
  always_comb begin
    state_n  = state_r;
    tok_dec  = 1'b0;
    gap_load = 1'b0;
    case (state_r)
      IDLE: begin
        if ((pending_r != '0) && token_en_i) begin
          state_n = PULSE;
          tok_dec = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      PULSE: begin
        if (token_gap_p > 0) begin
          state_n  = GAP;
          gap_load = 1'b1;
        end else if ((pending_r != '0) && token_en_i) begin
          state_n = PULSE;
          tok_dec = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      GAP: begin
        if (gap_done && (pending_r != '0) && token_en_i) begin
          state_n = PULSE;
          tok_dec = 1'b1;
        end else if (gap_done) begin
          state_n = IDLE;
        end else begin
          state_n = GAP;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and the registered pulse output.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
      token_r <= 1'b0;
    end else begin
      state_r <= state_n;
      token_r <= (state_n == PULSE);
    end
  end

`ifdef BSG_CREDIT_TOKEN_PACER_STATS_EN
  logic [31:0] total_r;
  // Emitted-token count, wraps naturally.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      total_r <= 32'd0;
    end else if (token_r) begin
      total_r <= total_r + 32'd1;
    end else begin
      total_r <= total_r;
    end
  end
  assign total_tokens_o = total_r;
`else
  assign total_tokens_o = 32'd0;
`endif

  assign token_o          = token_r;
  assign pending_tokens_o = pending_r;
  assign overflow_o       = overflow_r;

endmodule

// File: tb/tb_bsg_credit_token_pacer.sv
// Scoreboard bench: stimulus pushes expected pulse cycles, a forked monitor pops on every token_o.
module tb_bsg_credit_token_pacer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  logic credit_a = 1'b0, en_a = 1'b0, token_a, overflow_a;
  logic [2:0] pending_a;
  logic [0:0] partial_a;
  logic [31:0] total_a;

  logic credit_b = 1'b0, en_b = 1'b0, token_b, overflow_b;
  logic [2:0] pending_b;
  logic [1:0] partial_b;
  logic [31:0] total_b;

  logic credit_c = 1'b0, en_c = 1'b0, token_c, overflow_c;
  logic [2:0] pending_c;
  logic [0:0] partial_c;
  logic [31:0] total_c;

  int total = 0;
  int bad = 0;
  int exp_a[$];
  int exp_b[$];
  int exp_c[$];

  bsg_credit_token_pacer #(.lg_credit_to_token_decimation_p(0), .max_pending_tokens_p(4), .token_gap_p(1)) u_a (
    .clk_i(clk), .reset_n_i(rst_n), .credit_v_i(credit_a), .token_en_i(en_a), .token_o(token_a),
    .pending_tokens_o(pending_a), .partial_credits_o(partial_a), .overflow_o(overflow_a), .total_tokens_o(total_a));

  bsg_credit_token_pacer #(.lg_credit_to_token_decimation_p(2), .max_pending_tokens_p(4), .token_gap_p(1)) u_b (
    .clk_i(clk), .reset_n_i(rst_n), .credit_v_i(credit_b), .token_en_i(en_b), .token_o(token_b),
    .pending_tokens_o(pending_b), .partial_credits_o(partial_b), .overflow_o(overflow_b), .total_tokens_o(total_b));

  bsg_credit_token_pacer #(.lg_credit_to_token_decimation_p(0), .max_pending_tokens_p(4), .token_gap_p(0)) u_c (
    .clk_i(clk), .reset_n_i(rst_n), .credit_v_i(credit_c), .token_en_i(en_c), .token_o(token_c),
    .pending_tokens_o(pending_c), .partial_credits_o(partial_c), .overflow_o(overflow_c), .total_tokens_o(total_c));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (token_a) begin
        if (exp_a.size() == 0) check("a_spurious_pulse", 32'(token_a), 32'd0);
        else check("a_pulse_cycle", 32'(cyc), 32'(exp_a.pop_front()));
      end
      if (token_b) begin
        if (exp_b.size() == 0) check("b_spurious_pulse", 32'(token_b), 32'd0);
        else check("b_pulse_cycle", 32'(cyc), 32'(exp_b.pop_front()));
      end
      if (token_c) begin
        if (exp_c.size() == 0) check("c_spurious_pulse", 32'(token_c), 32'd0);
        else check("c_pulse_cycle", 32'(cyc), 32'(exp_c.pop_front()));
      end
    end
  endtask

  initial begin
    int t;
    int peak;
    logic [31:0] exp_total;
    fork
      monitor();
    join_none

    #2;
    check("rst_token", 32'(token_a), 32'd0);
    check("rst_pending", 32'(pending_a), 32'd0);
    check("rst_overflow", 32'(overflow_a), 32'd0);
    check("rst_partial_b", 32'(partial_b), 32'd0);
    check("rst_total", total_a, 32'd0);

    tick();
    rst_n = 1'b1;
    en_a = 1'b1;
    en_b = 1'b1;
    tick();

    // single credit: token exactly two cycles later
    t = cyc;
    credit_a = 1'b1;
    exp_a.push_back(t + 2);
    tick();
    credit_a = 1'b0;
    ticks(4);
    check("single_pending_back_to_0", 32'(pending_a), 32'd0);

    // credit held four cycles: pulses every other cycle, pending peaks at 2
    t = cyc;
    peak = 0;
    credit_a = 1'b1;
    for (int i = 1; i <= 4; i++) exp_a.push_back(t + 2 * i);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (int'(pending_a) > peak) peak = int'(pending_a);
    end
    credit_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (int'(pending_a) > peak) peak = int'(pending_a);
    end
    check("burst_peak_pending", 32'(peak), 32'd2);
    check("burst_pending_end", 32'(pending_a), 32'd0);

    // saturation with emission disabled, then drain
    en_a = 1'b0;
    credit_a = 1'b1;
    ticks(6);
    credit_a = 1'b0;
    tick();
    check("sat_pending", 32'(pending_a), 32'd4);
    check("sat_overflow", 32'(overflow_a), 32'd1);
    t = cyc;
    en_a = 1'b1;
    for (int i = 0; i < 4; i++) exp_a.push_back(t + 1 + 2 * i);
    ticks(10);
    check("drain_pending", 32'(pending_a), 32'd0);
    check("drain_overflow_sticky", 32'(overflow_a), 32'd1);

    // decimation by 4: 7 credits -> 1 token, partial 3; 8th -> 2nd token
    t = cyc;
    exp_b.push_back(t + 5);
    credit_b = 1'b1;
    ticks(7);
    credit_b = 1'b0;
    ticks(4);
    check("dec_partial_3", 32'(partial_b), 32'd3);
    check("dec_pending_b", 32'(pending_b), 32'd0);
    t = cyc;
    exp_b.push_back(t + 2);
    credit_b = 1'b1;
    tick();
    credit_b = 1'b0;
    ticks(4);
    check("dec_partial_0", 32'(partial_b), 32'd0);

    // no gap: three back-to-back pulses
    en_c = 1'b0;
    credit_c = 1'b1;
    ticks(3);
    credit_c = 1'b0;
    tick();
    check("nogap_pending_3", 32'(pending_c), 32'd3);
    t = cyc;
    en_c = 1'b1;
    for (int i = 1; i <= 3; i++) exp_c.push_back(t + i);
    ticks(6);
    check("nogap_pending_end", 32'(pending_c), 32'd0);
`ifdef BSG_CREDIT_TOKEN_PACER_STATS_EN
    exp_total = 32'd3;
`else
    exp_total = 32'd0;
`endif
    check("nogap_total", total_c, exp_total);

    // async reset while a pulse is high
    credit_b = 1'b1;
    tick();
    credit_b = 1'b0;
    tick();
    check("pre_rst_partial_b", 32'(partial_b), 32'd1);
    t = cyc;
    exp_a.push_back(t + 2);
    credit_a = 1'b1;
    ticks(2);
    credit_a = 1'b0;
    check("pre_rst_token", 32'(token_a), 32'd1);
    check("pre_rst_pending", 32'(pending_a), 32'd1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_token", 32'(token_a), 32'd0);
    check("mid_rst_pending", 32'(pending_a), 32'd0);
    check("mid_rst_partial_b", 32'(partial_b), 32'd0);
    check("mid_rst_overflow", 32'(overflow_a), 32'd0);
    exp_a.delete();
    ticks(2);
    rst_n = 1'b1;
    ticks(10);

    check("end_queue_a", 32'(exp_a.size()), 32'd0);
    check("end_queue_b", 32'(exp_b.size()), 32'd0);
    check("end_queue_c", 32'(exp_c.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
